// File: rtl/divide16_unsigned_pkg.sv
// Shared definitions for the sequential 32/16 unsigned divider.
// Contents: port widths, step-counter width, the divide-by-zero quotient constant
// and the FSM state encoding.
package divide16_unsigned_pkg;

  localparam int unsigned DW = 32;  // dividend / quotient / remainder width
  localparam int unsigned VW = 16;  // significant divisor width
  localparam int unsigned SW = 5;   // step counter width (DW steps)

  localparam logic [SW-1:0] LAST_STEP = SW'(DW - 1);
  localparam logic [DW-1:0] DIV0_Q    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divide16_unsigned_line.sv
// One combinational restoring-division step.
// Ports:
//   i_rem    partial remainder (always < divisor, so VW bits hold it)
//   i_shift  dividend/quotient shift register, next dividend bit in the MSB
//   i_div    divisor (non-zero)
//   o_rem    next partial remainder
//   o_shift  shift register moved left by one, LSB left 0 for the quotient bit
//   o_qbit   quotient bit produced by this step
module divide_line_1
  import divide16_unsigned_pkg::*;
(
  input  logic [VW-1:0] i_rem,
  input  logic [DW-1:0] i_shift,
  input  logic [VW-1:0] i_div,
  output logic [VW-1:0] o_rem,
  output logic [DW-1:0] o_shift,
  output logic          o_qbit
);

  logic [VW:0] w_p;
  logic [VW:0] w_diff;

  // 17-bit trial value: remainder shifted left with the next dividend bit.
  assign w_p    = {i_rem, i_shift[DW-1]};
  assign w_diff = w_p - {1'b0, i_div};

  // Since i_rem < i_div, p < 2*d: a non-negative difference is below 2^16,
  // so the top bit of the difference is exactly the borrow (p < d).
  assign o_qbit  = ~w_diff[VW];
  assign o_rem   = o_qbit ? w_diff[VW-1:0] : w_p[VW-1:0];
  assign o_shift = {i_shift[DW-2:0], 1'b0};

endmodule

// File: rtl/divide16_unsigned.sv
// Sequential restoring divider: 32-bit unsigned dividend / 16-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
// Ports:
//   clk, rst_n    clock (rising edge), synchronous active-low reset
//   start         request, sampled only while busy==0
//   dividend      32-bit dividend, latched when start is accepted
//   divisor       only the low 16 bits are used, latched when start is accepted
//   quotient      result, updated on entry to DONE and held
//   remainder     result, zero-extended; equals dividend on divide-by-zero
//   busy          high exactly while in RUN
//   done          one-cycle pulse when results are updated
//   div_by_zero   status of the last completed operation, held
module divide16_unsigned
  import divide16_unsigned_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero
);

  state_t        r_state;
  logic [DW-1:0] r_shift;     // remaining dividend bits, quotient bits fill from LSB
  logic [VW-1:0] r_rem;
  logic [VW-1:0] r_div;
  logic [SW-1:0] r_step;
  logic          r_dz;        // operation in flight is a divide-by-zero
  logic [DW-1:0] r_quotient;
  logic [DW-1:0] r_remainder;
  logic          r_busy;
  logic          r_done;
  logic          r_div_by_zero;

  logic [VW-1:0] w_rem;
  logic [DW-1:0] w_shift;
  logic          w_qbit;
  logic [DW-1:0] w_next_shift;
  logic          w_div_zero;
  logic          w_unused_div_hi;

  // Upper divisor bits are deliberately ignored.
  assign w_unused_div_hi = ^divisor[DW-1:VW];
  assign w_div_zero      = (divisor[VW-1:0] == '0);

  divide_line_1 u_line (
    .i_rem   (r_rem),
    .i_shift (r_shift),
    .i_div   (r_div),
    .o_rem   (w_rem),
    .o_shift (w_shift),
    .o_qbit  (w_qbit)
  );

  // Quotient bit drops into the LSB vacated by the shift.
  assign w_next_shift = w_shift | {{(DW-1){1'b0}}, w_qbit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_rem         <= '0;
      r_div         <= '0;
      r_step        <= '0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_shift <= dividend;
            r_rem   <= '0;
            r_div   <= divisor[VW-1:0];
            r_step  <= '0;
            r_dz    <= w_div_zero;
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (r_dz) begin
            // Divide-by-zero spends a single RUN cycle and reports the dividend back.
            r_quotient    <= DIV0_Q;
            r_remainder   <= r_shift;
            r_div_by_zero <= 1'b1;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_DONE;
          end else begin
            r_rem   <= w_rem;
            r_shift <= w_next_shift;
            r_step  <= r_step + 1'b1;
            if (r_step == LAST_STEP) begin
              r_quotient    <= w_next_shift;
              r_remainder   <= {{(DW-VW){1'b0}}, w_rem};
              r_div_by_zero <= 1'b0;
              r_done        <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= ST_DONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_divide16_unsigned.sv
module tb_divide16_unsigned;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  divide16_unsigned dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division on the low 16 divisor bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output int lat);
    logic [31:0] d;
    d = {16'h0, b[15:0]};
    if (d == 0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 1;
    end else begin
      q = a / d; r = a % d; dz = 1'b0; lat = 32;
    end
  endfunction

  // Issue one operation and count edges from acceptance until done (-1 on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; dividend = 32'd50; divisor = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (quotient !== 32'h0) begin errors++;
      $display("FAIL reset_quotient got %h want 0", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++;
      $display("FAIL reset_remainder got %h want 0", remainder); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL reset_done got %b want 0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++;
      $display("FAIL reset_dz got %b want 0", div_by_zero); end
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [6] = '{32'h0123_4321, 32'h0123_4322, 32'hFFFF_FFFF,
                            32'h1234_5678, 32'h0000_000A, 32'hFFFF_FFFF};
    logic [31:0] tb [6] = '{32'h0000_1111, 32'h0000_1111, 32'h0000_FFFF,
                            32'h0000_0000, 32'hABCD_0003, 32'h0000_0001};
    logic [31:0] tq [6] = '{32'h0000_1111, 32'h0000_1111, 32'h0001_0001,
                            32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF};
    logic [31:0] tr [6] = '{32'h0, 32'h1, 32'h0, 32'h1234_5678, 32'h1, 32'h0};
    logic        tz [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int          tl [6] = '{32, 32, 32, 1, 32, 32};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], lat);
      checks++; if (lat != tl[i]) begin errors++;
        $display("FAIL dir%0d_latency got %0d want %0d", i, lat, tl[i]); end
      checks++; if (quotient !== tq[i]) begin errors++;
        $display("FAIL dir%0d_quotient got %h want %h", i, quotient, tq[i]); end
      checks++; if (remainder !== tr[i]) begin errors++;
        $display("FAIL dir%0d_remainder got %h want %h", i, remainder, tr[i]); end
      checks++; if (div_by_zero !== tz[i]) begin errors++;
        $display("FAIL dir%0d_dz got %b want %b", i, div_by_zero, tz[i]); end
      checks++; if (busy !== 1'b0) begin errors++;
        $display("FAIL dir%0d_busy_with_done got %b want 0", i, busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++;
        $display("FAIL dir%0d_done_pulse got %b want 0", i, done); end
      checks++; if (quotient !== tq[i] || remainder !== tr[i]) begin errors++;
        $display("FAIL dir%0d_held got %h/%h want %h/%h", i, quotient, remainder,
                 tq[i], tr[i]); end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    repeat (10) begin @(posedge clk); #1; lat++; end
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL ign_busy got %b want 1", busy); end
    @(negedge clk);
    dividend = 32'd5; divisor = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    lat++; start = 1'b0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 32) begin errors++;
      $display("FAIL ign_latency got %0d want 32", lat); end
    checks++; if (quotient !== 32'd14 || remainder !== 32'd2) begin errors++;
      $display("FAIL ign_result got %0d/%0d want 14/2", quotient, remainder); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL ign_no_queue got busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] q, r;
    logic dz;
    int el;
    int overlap;
    run_op(32'd1000, 32'd7, lat);
    checks++; if (lat != 32 || quotient !== 32'd142 || remainder !== 32'd6) begin errors++;
      $display("FAIL b2b_first got lat %0d %0d/%0d want 32 142/6", lat, quotient, remainder);
    end
    // Still inside the DONE cycle: request the next operation right away.
    dividend = 32'hDEAD_BEEF; divisor = 32'h5555_1234; start = 1'b1;
    model(32'hDEAD_BEEF, 32'h5555_1234, q, r, dz, el);
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL b2b_accept got busy %b done %b want 1 0", busy, done); end
    checks++; if (quotient !== 32'd142) begin errors++;
      $display("FAIL b2b_held_early got %0d want 142", quotient); end
    lat = 0; overlap = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (done === 1'b1 && busy === 1'b1) overlap++;
    end
    checks++; if (lat != el) begin errors++;
      $display("FAIL b2b_latency got %0d want %0d", lat, el); end
    checks++; if (quotient !== q || remainder !== r) begin errors++;
      $display("FAIL b2b_second got %h/%h want %h/%h", quotient, remainder, q, r); end
    checks++; if (overlap != 0) begin errors++;
      $display("FAIL b2b_done_busy_overlap got %0d want 0", overlap); end
  endtask

  task automatic test_reset_mid_run();
    int lat, el, saw;
    logic [31:0] q, r, a;
    logic dz;
    @(negedge clk);
    dividend = 32'h8765_4321; divisor = 32'h0000_00FF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    checks++; if (quotient !== 0 || remainder !== 0 || busy !== 0 || done !== 0 ||
                  div_by_zero !== 0) begin errors++;
      $display("FAIL midrst_outputs got %h %h %b %b %b want all 0", quotient, remainder,
               busy, done, div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    saw = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) saw++; end
    checks++; if (saw != 0) begin errors++;
      $display("FAIL midrst_no_done got %0d done cycles want 0", saw); end
    a = $urandom;
    model(a, 32'h0000_0ACE, q, r, dz, el);
    run_op(a, 32'h0000_0ACE, lat);
    checks++; if (lat != el || quotient !== q || remainder !== r || div_by_zero !== dz)
    begin errors++;
      $display("FAIL midrst_fresh got lat %0d %h/%h want %0d %h/%h", lat, quotient,
               remainder, el, q, r); end
  endtask

  task automatic test_random();
    int lat, el;
    logic [31:0] a, b, q, r;
    logic dz;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = {$urandom_range(0, 65535), 16'h0} | $urandom_range(1, 15);
        2: b = {$urandom_range(1, 65535), 16'h0};
        default: b = 32'h0000_FFFF - $urandom_range(0, 3);
      endcase
      model(a, b, q, r, dz, el);
      run_op(a, b, lat);
      checks++; if (lat != el) begin errors++;
        $display("FAIL rnd%0d_latency got %0d want %0d", n, lat, el); end
      checks++; if (quotient !== q) begin errors++;
        $display("FAIL rnd%0d_quotient %h/%h got %h want %h", n, a, b, quotient, q); end
      checks++; if (remainder !== r) begin errors++;
        $display("FAIL rnd%0d_remainder %h/%h got %h want %h", n, a, b, remainder, r); end
      checks++; if (div_by_zero !== dz) begin errors++;
        $display("FAIL rnd%0d_dz got %b want %b", n, div_by_zero, dz); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
